mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin memory arbiter: NUM_PORTS masters share one memory port.
// Grants are combinational, the accepted command is registered onto the
// memory bus, and read responses are routed back by a fixed-latency
// {valid, port} tracking pipeline.
module mem_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]             req_re,
    input  logic [NUM_PORTS-1:0]             req_we,
    output logic [NUM_PORTS-1:0]             req_gnt,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_re,
    output logic                             mem_we,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Arbitration state and the selected requester
    logic [IDX_W-1:0]      last_reg;
    logic [NUM_PORTS-1:0]  req_any;
    logic                  gnt_found;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_re;
    logic                  sel_we;

    // Registered memory command
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic                  mem_re_reg;
    logic                  mem_we_reg;

    // Read tracking pipeline: stage k is visible k+1 cycles after the grant
    logic                  pipe_valid_reg [0:MEM_LATENCY];
    logic [IDX_W-1:0]      pipe_port_reg  [0:MEM_LATENCY];

    // Response registers
    logic [NUM_PORTS-1:0]  rsp_valid_reg;
    logic [NUM_PORTS-1:0]  rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;

    // (base + off) mod NUM_PORTS without a general modulo; off is 1..NUM_PORTS
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return IDX_W'(sum);
    endfunction

    assign req_any = req_re | req_we;

    // Round-robin search starting just after the last granted port
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!gnt_found && req_any[wrap_idx(last_reg, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(last_reg, k);
            end
        end
    end

    // Grants are suppressed while reset is held, even though requests may be present
    assign gnt_valid = gnt_found & rst;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
            assign req_gnt[gi] = gnt_valid && (gnt_idx == IDX_W'(gi));
        end
    endgenerate

    // Pick the winning port's command; read+write together counts as a write
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_we    = req_we[gnt_idx];
    assign sel_re    = req_re[gnt_idx] & ~req_we[gnt_idx];

    // Register the accepted command and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_reg      <= IDX_W'(NUM_PORTS - 1);
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
        end else begin
            mem_re_reg <= gnt_found & sel_re;
            mem_we_reg <= gnt_found & sel_we;
            if (gnt_found) begin
                last_reg      <= gnt_idx;
                mem_addr_reg  <= sel_addr;
                mem_wdata_reg <= sel_wdata;
            end
        end
    end

    // First tracking stage records which port a read belongs to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_port_reg[0]  <= '0;
        end else begin
            pipe_valid_reg[0] <= gnt_found & sel_re;
            pipe_port_reg[0]  <= gnt_idx;
        end
    end

    generate
        for (genvar gi = 1; gi <= MEM_LATENCY; gi++) begin : g_pipe
            // Shift the read tag one stage per cycle to match memory latency
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_port_reg[gi]  <= '0;
                end else begin
                    pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    pipe_port_reg[gi]  <= pipe_port_reg[gi-1];
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
            assign rsp_valid_next[gi] = pipe_valid_reg[MEM_LATENCY] &&
                                        (pipe_port_reg[MEM_LATENCY] == IDX_W'(gi));
        end
    endgenerate

    // Capture memory data when the tag leaves the pipeline; data holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            if (pipe_valid_reg[MEM_LATENCY]) begin
                rsp_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-accurate memory device plus a
// transaction-level reference (round-robin rule, ordered response queue,
// shadow memory) checked every cycle.
module tb_mem_arbiter;
    localparam int NP  = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP-1:0]     req_re;
    logic [NP-1:0]     req_we;
    logic [NP-1:0]     req_gnt;
    logic [DW-1:0]     rsp_rdata;
    logic [NP-1:0]     rsp_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_re   (req_re),
        .req_we   (req_we),
        .req_gnt  (req_gnt),
        .rsp_rdata(rsp_rdata),
        .rsp_valid(rsp_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    // Memory device: 256 words, data valid LAT cycles after mem_re, garbage otherwise
    bit            dev_ready = 1'b0;
    logic [DW-1:0] dev_mem  [0:255];
    logic [DW-1:0] lat_pipe [LAT];

    always @(posedge clk) begin
        if (!dev_ready) begin
            for (int k = 0; k < 256; k++) dev_mem[k] <= init_val(AW'(k));
            dev_ready <= 1'b1;
        end else if (mem_we) begin
            dev_mem[mem_addr[7:0]] <= mem_wdata;
        end
        lat_pipe[0] <= mem_re ? dev_mem[mem_addr[7:0]] : DW'($urandom);
        for (int k = 1; k < LAT; k++) lat_pipe[k] <= lat_pipe[k-1];
    end
    assign mem_rdata = lat_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] model_mem [0:255];
    int            m_last;
    int            cyc;
    logic          exp_re, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_rdata_last;
    logic [NP-1:0] pend;
    int            mode;
    logic [AW-1:0] seq_addr;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // New requests for idle ports; pending ports keep their request until granted
    task automatic gen_requests();
        for (int p = 0; p < NP; p++) begin
            if (!pend[p]) begin
                logic          do_req;
                logic          r;
                logic          w;
                logic [AW-1:0] a;
                int            kind;
                do_req = 1'b0;
                r      = 1'b0;
                w      = 1'b0;
                a      = AW'($urandom_range(0, 255));
                case (mode)
                    1: begin do_req = 1'b1; r = 1'b1; end
                    2: if (p == 0) begin
                        do_req   = 1'b1;
                        r        = 1'b1;
                        a        = seq_addr;
                        seq_addr = seq_addr + 1'b1;
                    end
                    3: begin
                        do_req = ($urandom_range(0, 9) < 6);
                        kind   = $urandom_range(0, 3);
                        r      = (kind != 2);
                        w      = (kind >= 2);
                        a      = AW'($urandom_range(0, 31));
                    end
                    default: do_req = 1'b0;
                endcase
                pend[p]                = do_req;
                req_re[p]              = do_req & r;
                req_we[p]              = do_req & w;
                req_addr[p*AW +: AW]   = a;
                req_wdata[p*DW +: DW]  = DW'($urandom);
            end
        end
    endtask

    // One clock cycle: check the grant, advance the model, check registered outputs
    task automatic step();
        logic [NP-1:0] reqs;
        logic [NP-1:0] eg;
        logic [NP-1:0] ev;
        int            g;
        gen_requests();
        #1;
        reqs = req_re | req_we;
        g = -1;
        for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (m_last + k) % NP;
            if (g < 0 && reqs[idx]) g = idx;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check("req_gnt", req_gnt, eg);

        exp_re = 1'b0;
        exp_we = 1'b0;
        if (g >= 0) begin
            exp_addr  = req_addr[g*AW +: AW];
            exp_wdata = req_wdata[g*DW +: DW];
            if (req_we[g]) begin
                exp_we = 1'b1;
                model_mem[exp_addr[7:0]] = exp_wdata;
            end else begin
                exp_re = 1'b1;
                rq.push_back('{due: cyc + 2 + LAT, port: g, data: model_mem[exp_addr[7:0]]});
            end
            m_last  = g;
            pend[g] = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
        check("mem_re", mem_re, exp_re);
        check("mem_we", mem_we, exp_we);
        if (exp_re || exp_we) check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);

        ev = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev[rq[0].port] = 1'b1;
            exp_rdata_last = rq[0].data;
            void'(rq.pop_front());
        end
        check("rsp_valid", rsp_valid, ev);
        check("rsp_rdata", rsp_rdata, exp_rdata_last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   req_gnt,   '0);
        check({tag, "_rspv"},  rsp_valid, '0);
        check({tag, "_rspd"},  rsp_rdata, '0);
        check({tag, "_addr"},  mem_addr,  '0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_re"},    mem_re,    1'b0);
        check({tag, "_we"},    mem_we,    1'b0);
    endtask

    // Assert reset mid-cycle with requests still present, then clear the model
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        rq.delete();
        m_last         = NP - 1;
        exp_rdata_last = '0;
        pend           = '0;
        req_re         = '0;
        req_we         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_re    = '0;
        req_we    = '0;
        pend      = '0;
        mode      = 0;
        seq_addr  = '0;
        cyc       = 0;
        m_last    = NP - 1;
        exp_re    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rdata_last = '0;
        for (int k = 0; k < 256; k++) model_mem[k] = init_val(AW'(k));

        // Power-on reset: requests present but no grant allowed
        req_re = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        req_re = '0;
        rst = 1'b1;

        // All ports reading continuously: rotation 0,1,2,3,...
        mode = 1;
        repeat (12) step();
        mode = 0;
        repeat (LAT + 4) step();

        // Port 1 read+write together is a write; port 2 then reads it back
        pend[1] = 1'b1;
        req_re[1] = 1'b1;
        req_we[1] = 1'b1;
        req_addr[1*AW +: AW]  = 16'h0004;
        req_wdata[1*DW +: DW] = 16'h1234;
        step();
        check("wr_mem_wdata", mem_wdata, 16'h1234);
        pend[2] = 1'b1;
        req_re[2] = 1'b1;
        req_we[2] = 1'b0;
        req_addr[2*AW +: AW] = 16'h0004;
        step();
        repeat (LAT + 4) step();
        check("rd_back_1234", rsp_rdata, 16'h1234);

        // Single requester back-to-back reads from address 0 upward
        mode = 2;
        seq_addr = '0;
        repeat (4) step();
        mode = 0;
        repeat (LAT + 4) step();

        // Random mix of reads, writes and combined strobes
        mode = 3;
        repeat (300) step();
        mode = 0;
        repeat (LAT + 4) step();

        // Reset one cycle after a read grant: in-flight reads are dropped
        mode = 1;
        repeat (3) step();
        do_reset();
        step();
        check("post_rst_first_gnt_port", m_last, 0);
        repeat (5) step();
        mode = 0;
        repeat (LAT + 6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
